cacheline_burst_adapter: RTL and testbench

CACHELINE_BURST_ADAPTER -- requirements
Module: cacheline_burst_adapter

---
 rtl/cacheline_burst_adapter_pkg.sv | 15 +
 rtl/cacheline_burst_adapter_line_beat_buffer.sv | 42 ++++
 rtl/cacheline_burst_adapter.sv | 104 ++++++++++
 tb/tb_cacheline_burst_adapter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared types and default geometry for the cacheline-to-burst adapter.
package cacheline_burst_adapter_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cacheline_burst_adapter_line_beat_buffer.sv
// Cacheline-wide buffer: whole-line load, or one beat written at a time,
// with the currently indexed beat presented on beat_q.
module line_beat_buffer #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int BEATS   = LINE_W / BURST_W,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [LINE_W-1:0]  load_data,
  input  logic               beat_we,
  input  logic [IDX_W-1:0]   beat_idx,
  input  logic [BURST_W-1:0] beat_wdata,
  output logic [LINE_W-1:0]  line_q,
  output logic [BURST_W-1:0] beat_q
);

  logic [BURST_W-1:0] slice_reg [BEATS];

  // Reset clears the line; a whole-line load beats a single-beat write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BEATS; i++) begin
      if (rst) begin
        slice_reg[i] <= '0;
      end else if (load_en) begin
        slice_reg[i] <= load_data[i*BURST_W +: BURST_W];
      end else if (beat_we && (beat_idx == IDX_W'(i))) begin
        slice_reg[i] <= beat_wdata;
      end
    end
  end

  // Beat 0 occupies the least significant bits of the line.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
    assign line_q[gi*BURST_W +: BURST_W] = slice_reg[gi];
  end

  assign beat_q = slice_reg[beat_idx];

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Splits one cacheline read/write into BEATS memory beats and reassembles
// read beats into a line; Moore FSM with a one-cycle completion pulse.
module cacheline_burst_adapter #(
  parameter int LINE_W  = cacheline_burst_adapter_pkg::LINE_W,
  parameter int BURST_W = cacheline_burst_adapter_pkg::BURST_W,
  parameter int BEATS   = LINE_W / BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_addr,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  output logic [31:0]        burst_addr,
  output logic               burst_read,
  output logic               burst_write,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
);

  import cacheline_burst_adapter_pkg::*;

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [31:0]        addr_reg;
  logic               start_req;
  logic               in_burst;
  logic               beat_take;
  logic               last_beat;
  logic [LINE_W-1:0]  line_q;
  logic [BURST_W-1:0] beat_q;

  assign start_req = (state_reg == IDLE) && (line_read || line_write);
  assign in_burst  = (state_reg == READ) || (state_reg == WRITE);
  assign beat_take = in_burst && burst_resp;
  assign last_beat = (cnt_reg == CNT_W'(BEATS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: write has priority; DONE always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (line_write)     state_next = WRITE;
        else if (line_read) state_next = READ;
      end
      READ, WRITE: begin
        if (beat_take && last_beat) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat counter and aligned address; responses outside a burst are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      addr_reg <= '0;
    end else begin
      if (start_req) addr_reg <= {line_addr[31:5], 5'b0};
      if (beat_take) cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
    end
  end

  line_beat_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .BEATS   (BEATS),
    .IDX_W   (CNT_W)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .load_en    (start_req),
    .load_data  (line_wdata),
    .beat_we    (beat_take && (state_reg == READ)),
    .beat_idx   (cnt_reg),
    .beat_wdata (burst_rdata),
    .line_q     (line_q),
    .beat_q     (beat_q)
  );

  // Moore outputs decoded from state and registers.
  always_comb begin
    line_resp   = (state_reg == DONE);
    burst_read  = (state_reg == READ);
    burst_write = (state_reg == WRITE);
    burst_addr  = addr_reg;
    burst_wdata = (state_reg == WRITE) ? beat_q : '0;
  end

  assign line_rdata = line_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed scoreboard bench for cacheline_burst_adapter.
module tb_cacheline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_addr;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_addr;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int n_vec = 0;
  int n_err = 0;
  int resp_count = 0;

  logic [31:0]  exp_addr_q [$];
  logic [63:0]  exp_wbeat_q [$];
  logic [255:0] exp_line_q [$];

  always #5 clk = ~clk;

  cacheline_burst_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .line_addr   (line_addr),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_addr  (burst_addr),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_wdata (burst_wdata),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected beats/lines whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (burst_resp && (burst_read || burst_write)) begin
        if (exp_addr_q.size() == 0) check("beat_unexpected", 256'(1), 256'(0));
        else check("burst_addr", 256'(burst_addr), 256'(exp_addr_q.pop_front()));
        if (burst_write) begin
          if (exp_wbeat_q.size() == 0) check("wbeat_unexpected", 256'(1), 256'(0));
          else check("burst_wdata", 256'(burst_wdata), 256'(exp_wbeat_q.pop_front()));
        end
      end
      if (line_resp) begin
        resp_count++;
        if (exp_line_q.size() == 0) check("line_resp_unexpected", 256'(1), 256'(0));
        else begin
          check("line_rdata", line_rdata, exp_line_q.pop_front());
          $display("line_resp: line_rdata=%h", line_rdata);
        end
      end
    end
  end

  task automatic check_active(input bit rd, input bit wr);
    check("burst_read_level", 256'(burst_read), 256'(rd && !wr));
    check("burst_write_level", 256'(burst_write), 256'(wr));
    check("line_resp_early", 256'(line_resp), 256'(0));
  endtask

  // One full line transaction; expected values are supplied by the caller.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] exp_addr, input logic [255:0] wdata,
                         input logic [255:0] rbeats, input logic [255:0] exp_line,
                         input int gap, input bit hold_req);
    for (int b = 0; b < 4; b++) begin
      exp_addr_q.push_back(exp_addr);
      if (wr) exp_wbeat_q.push_back(wdata[64*b +: 64]);
    end
    exp_line_q.push_back(exp_line);
    burst_resp = 1'b0;
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = wdata;
    tick();
    line_addr  = ~addr;
    line_wdata = ~wdata;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        burst_resp = 1'b0;
        @(negedge clk);
        check_active(rd, wr);
        tick();
      end
      burst_resp  = 1'b1;
      burst_rdata = rbeats[64*b +: 64];
      @(negedge clk);
      check_active(rd, wr);
      tick();
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
    if (!hold_req) begin
      line_read  = 1'b0;
      line_write = 1'b0;
    end
    @(negedge clk);
    check("line_resp_done", 256'(line_resp), 256'(1));
    check("burst_read_done", 256'(burst_read), 256'(0));
    check("burst_write_done", 256'(burst_write), 256'(0));
    tick();
    @(negedge clk);
    check("line_resp_single", 256'(line_resp), 256'(0));
    check("burst_read_idle", 256'(burst_read), 256'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_line_resp"}, 256'(line_resp), 256'(0));
    check({tag, "_burst_read"}, 256'(burst_read), 256'(0));
    check({tag, "_burst_write"}, 256'(burst_write), 256'(0));
    check({tag, "_burst_addr"}, 256'(burst_addr), 256'(0));
    check({tag, "_burst_wdata"}, 256'(burst_wdata), 256'(0));
    check({tag, "_line_rdata"}, line_rdata, 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every request input active: reset must dominate.
    rst = 1'b1; line_read = 1'b1; line_write = 1'b1; line_addr = 32'hFFFF_FFFF;
    line_wdata = {4{64'hFFFF_FFFF_FFFF_FFFF}}; burst_resp = 1'b1; burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); tick();
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0; line_read = 1'b0; line_write = 1'b0; burst_resp = 1'b0;
    line_addr = '0; line_wdata = '0; burst_rdata = '0;
    tick();

    // Back-to-back read of 0x1234: aligned to 0x1220.
    $display("txn: read 0x00001234 back-to-back");
    run_txn(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            0, 1'b0);

    // Write with two-cycle gaps; read data driven but must not land in the buffer.
    $display("txn: write 0x00004567 gaps=2");
    run_txn(1'b0, 1'b1, 32'h0000_4567, 32'h0000_4560,
            {64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
            {4{64'hDEAD_BEEF_DEAD_BEEF}},
            {64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
            2, 1'b0);

    // Read and write together: write wins.
    $display("txn: read+write 0xFFFFFFFF gaps=1");
    run_txn(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
            {64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000},
            {4{64'h1234_1234_1234_1234}},
            {64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000},
            1, 1'b0);

    // Reset after two beats of a read: aborted, no line_resp.
    $display("txn: read 0x00002010 aborted by reset after beat 2");
    exp_addr_q.push_back(32'h0000_2000);
    exp_addr_q.push_back(32'h0000_2000);
    line_read = 1'b1; line_addr = 32'h0000_2010;
    tick();
    for (int b = 0; b < 2; b++) begin
      burst_resp = 1'b1; burst_rdata = 64'h9999_0000_0000_0000 | 64'(b);
      tick();
    end
    burst_resp = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; line_read = 1'b0; line_addr = '0; line_wdata = '0;
    @(negedge clk);
    check_all_zero("abort");
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      check("abort_no_resp", 256'(line_resp), 256'(0));
    end

    $display("txn: fresh read 0x00000040 after abort");
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040, '0,
            {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
            {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
            0, 1'b0);

    // Spurious beat in IDLE must not touch the buffer or counter.
    $display("txn: spurious burst_resp in IDLE, then read 0x1000003F");
    tick();
    burst_resp = 1'b1; burst_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    @(negedge clk);
    check("spurious_no_burst", 256'(burst_read | burst_write), 256'(0));
    run_txn(1'b1, 1'b0, 32'h1000_003F, 32'h1000_0020, '0,
            {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
            {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
            0, 1'b0);

    // Request held through DONE: re-issued immediately after the IDLE cycle.
    $display("txn: read 0x80000000 held across DONE (two lines)");
    run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, '0,
            {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0},
            {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0},
            0, 1'b1);
    run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, '0,
            {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0},
            {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0},
            0, 1'b0);

    tick(); tick();
    check("line_resp_total", 256'(resp_count), 256'(7));
    check("addr_q_drained", 256'(exp_addr_q.size()), 256'(0));
    check("wbeat_q_drained", 256'(exp_wbeat_q.size()), 256'(0));
    check("line_q_drained", 256'(exp_line_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
